fifo_resultados_arbiter: RTL and testbench
==========================================

Name: fifo_resultados_arbiter

Overview:
- Capture controller and round-robin arbiter in front of the 32-bit, 1024-word result FIFO.
- Merges up to N_SRC Avalon-ST result sources into the FIFO write port.
- Gates writes into a host-armed capture of LENGTH words and stalls sources on FIFO full.
- Reports busy/done/stall status through a small Avalon-MM CSR slave on the same clock as the FIFO.

Parameters:
- N_SRC, 4, number of result sources (1..8)
- DATA_W, 32, sample width; equals FIFO width
- CNT_W, 16, width of LENGTH and COUNT registers

Ports:
- clock  in  1  single system clock; the FIFO's clock
- reset  in  1  synchronous, active-high reset
- src_data  in  N_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- src_valid  in  N_SRC  per-source valid
- src_ready  out  N_SRC  per-source ready; a transfer occurs when valid&ready
- fifo_data  out  DATA_W  to FIFO data
- fifo_wrreq  out  1  to FIFO wrreq
- fifo_full  in  1  from FIFO full
- csr_address  in  2  word address
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, 1-cycle read latency
- capture_done  out  1  level interrupt; mirrors STATUS.done

Behaviour:
- Reset values: src_ready=0, fifo_wrreq=0, fifo_data=0, csr_readdata=0, capture_done=0, LENGTH=0, COUNT=0, enable mask=all ones, RR pointer=0, state=IDLE.
- CSR map:
  - 0 CONTROL (W): bit0 start (write-1 pulse), bit1 abort (write-1 pulse), bits[8+N_SRC-1:8] source enable mask. Reads return the mask in the same bits; bits 0 and 1 read 0.
  - 1 LENGTH (R/W).
  - 2 STATUS: R = bit0 busy, bit1 done, bit2 stalled. W = write 1 to bit1 or bit2 clears that bit.
  - 3 COUNT (R): words written in the current or last capture.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE, start: COUNT←0, done←0, stalled←0. Go to CAPTURE, or directly to DONE (done←1) if LENGTH==0.
  - CAPTURE, accepted word brings COUNT to LENGTH: go to DONE, done←1.
  - CAPTURE, abort: go to IDLE. COUNT is kept, done stays 0.
  - DONE: behaves as IDLE for start; done remains sticky until cleared or a new start.
  - Start while in CAPTURE is ignored. Abort outside CAPTURE has no effect.
  - Start and abort in the same write: abort wins.
- Arbitration (combinational, zero latency):
  - Eligible sources = src_valid & mask.
  - grant = first eligible index at or after the RR pointer, wrapping N_SRC-1→0.
  - src_ready[grant] = (state==CAPTURE) & ~fifo_full. All other src_ready bits are 0.
  - Accept = granted valid & ready. fifo_wrreq=accept; fifo_data=src_data of the granted source.
  - At most one word per cycle.
  - After each accept, the pointer becomes grant+1 mod N_SRC. The pointer does not move on idle cycles.
- Backpressure:
  - While fifo_full, no writes occur; the FIFO is never overflowed.
  - stalled←1 (sticky) if in CAPTURE, fifo_full, and any eligible source is valid.
- Outside CAPTURE, all src_ready bits are 0. Sources are held, not dropped.
- Mask changes take effect on the next cycle. A mask of 0 in CAPTURE stalls forever; only abort exits.
- COUNT saturates at LENGTH; the final word of a capture is written exactly once.
- Reset mid-capture returns to IDLE with reset values. Words already written stay in the FIFO; the FIFO has its own reset.
- CSR read data is registered from address and state on the read cycle; it appears the next cycle.

Decomposition:
- Shared package holds:
  - CSR address constants: ADDR_CONTROL, ADDR_LENGTH, ADDR_STATUS, ADDR_COUNT.
  - Bit-position constants: START, ABORT, MASK_LSB, BUSY, DONE, STALLED.
  - FSM state encoding.
- One sub-module: rr_arbiter (N_SRC request vector + pointer → one-hot grant + index). Reusable by other multi-source blocks.

Test Plan:
- Single source: LENGTH=5, start, src0 streams 0x10..0x14 → exactly 5 wrreq pulses with data 0x10..0x14; COUNT=5; done=1; capture_done=1; src_ready drops the cycle after the last accept.
- Four sources all valid continuously, LENGTH=8 → grant order 0,1,2,3,0,1,2,3; one write per cycle; final RR pointer=0.
- Mask=0b1010 with all four sources valid, LENGTH=4 → only sources 1,3 are served, order 1,3,1,3; sources 0,2 see ready=0 throughout.
- fifo_full asserted for 3 cycles mid-capture with src0 valid → no wrreq during those cycles; stalled=1; capture resumes; total words still equals LENGTH; no word lost or duplicated.
- LENGTH=0 then start → immediate DONE; zero writes; COUNT=0.
- Abort after 3 of 10 words → state IDLE; COUNT=3; done=0; src_ready=0. A subsequent start clears COUNT and completes 10 words. A reset pulse at word 2 of another capture → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fifo_resultados_arbiter_pkg.sv
// Shared constants for the result-FIFO capture controller: CSR map, bit positions, FSM encoding.
package fifo_resultados_arbiter_pkg;

    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_LENGTH  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    localparam int unsigned START    = 0;
    localparam int unsigned ABORT    = 1;
    localparam int unsigned MASK_LSB = 8;
    localparam int unsigned BUSY     = 0;
    localparam int unsigned DONE     = 1;
    localparam int unsigned STALLED  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Index reached by stepping 'off' places from 'base' on a ring of n slots.
    function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fifo_resultados_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer, wrapping N-1 to 0.
module rr_arbiter
    import fifo_resultados_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [PTR_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = PTR_W'(rr_wrap(32'(i_ptr), k, N));
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_resultados_arbiter.sv
// Capture controller and round-robin merge of N_SRC Avalon-ST sources into the result FIFO,
// with an Avalon-MM CSR slave for arming, aborting and status.
module fifo_resultados_arbiter
    import fifo_resultados_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    fifo_wrreq,
    input  logic                    fifo_full,
    input  logic [1:0]              csr_address,
    input  logic                    csr_read,
    input  logic                    csr_write,
    input  logic [31:0]             csr_writedata,
    output logic [31:0]             csr_readdata,
    output logic                    capture_done
);

    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_length;
    logic [CNT_W-1:0]   r_count;
    logic [N_SRC-1:0]   r_mask;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_done;
    logic               r_stalled;
    logic [31:0]        r_readdata;

    logic [N_SRC-1:0]   w_req;
    logic [N_SRC-1:0]   w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic               w_busy;
    logic               w_ready_en;
    logic               w_accept;
    logic               w_last;
    logic               w_ctrl_wr;
    logic               w_stat_wr;
    logic               w_start;
    logic               w_abort;
    logic               w_go;
    logic               w_stall_evt;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wd;

    assign w_ctrl_wr   = csr_write && (csr_address == ADDR_CONTROL);
    assign w_stat_wr   = csr_write && (csr_address == ADDR_STATUS);
    assign w_start     = w_ctrl_wr && csr_writedata[START];
    assign w_abort     = w_ctrl_wr && csr_writedata[ABORT];
    assign w_go        = (r_state != ST_CAPTURE) && w_start && !w_abort;
    assign w_req       = src_valid & r_mask;
    assign w_last      = ({1'b0, r_count} + (CNT_W+1)'(1)) >= {1'b0, r_length};
    assign w_stall_evt = w_busy && fifo_full && (|w_req);
    assign w_unused_wd = ^csr_writedata;

    rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Start is ignored mid-capture; abort only acts mid-capture and beats a simultaneous start.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_go) w_state_nxt = (r_length == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_abort)                w_state_nxt = ST_IDLE;
                else if (w_accept && w_last) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == ST_CAPTURE);
        w_ready_en = w_busy && !fifo_full;
        w_accept   = w_ready_en && w_any;
        src_ready  = w_ready_en ? w_grant : '0;
        fifo_wrreq = w_accept;
        fifo_data  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (w_accept && w_grant[i]) fifo_data = src_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_length  <= '0;
            r_count   <= '0;
            r_mask    <= '1;
            r_ptr     <= '0;
            r_done    <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            if (csr_write && (csr_address == ADDR_LENGTH)) r_length <= csr_writedata[CNT_W-1:0];
            if (w_ctrl_wr) r_mask <= csr_writedata[MASK_LSB +: N_SRC];
            if (w_accept) r_ptr <= (w_idx == PTR_W'(N_SRC - 1)) ? '0 : w_idx + PTR_W'(1);

            // Count clamps to LENGTH so the final word closes the capture exactly once.
            if (w_go)          r_count <= '0;
            else if (w_accept) r_count <= w_last ? r_length : r_count + CNT_W'(1);

            if (w_go)                                   r_done <= (r_length == '0);
            else if (w_accept && w_last && !w_abort)    r_done <= 1'b1;
            else if (w_stat_wr && csr_writedata[DONE])  r_done <= 1'b0;

            if (w_go)                                     r_stalled <= 1'b0;
            else if (w_stall_evt)                         r_stalled <= 1'b1;
            else if (w_stat_wr && csr_writedata[STALLED]) r_stalled <= 1'b0;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (csr_address)
            ADDR_CONTROL: w_rd_mux[MASK_LSB +: N_SRC] = r_mask;
            ADDR_LENGTH:  w_rd_mux[CNT_W-1:0] = r_length;
            ADDR_STATUS: begin
                w_rd_mux[BUSY]    = w_busy;
                w_rd_mux[DONE]    = r_done;
                w_rd_mux[STALLED] = r_stalled;
            end
            default:      w_rd_mux[CNT_W-1:0] = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)         r_readdata <= '0;
        else if (csr_read) r_readdata <= w_rd_mux;
    end

    assign csr_readdata = r_readdata;
    assign capture_done = r_done;

endmodule

// File: tb/tb_fifo_resultados_arbiter.sv
// Bench for fifo_resultados_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_resultados_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [DW-1:0]   fifo_data;
    logic            fifo_wrreq;
    logic            fifo_full = 1'b0;
    logic [1:0]      csr_address = '0;
    logic            csr_read = 1'b0;
    logic            csr_write = 1'b0;
    logic [31:0]     csr_writedata = '0;
    logic [31:0]     csr_readdata;
    logic            capture_done;

    fifo_resultados_arbiter #(.N_SRC(N), .DATA_W(DW), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .fifo_data     (fifo_data),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_full     (fifo_full),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .capture_done  (capture_done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int full_wr = 0;

    typedef struct { int src; logic [31:0] data; int cyc; } wr_t;
    wr_t wlog[$];

    // Source behaviour: each source offers words while it has budget; random mode toggles offers.
    int unsigned budget[N];
    int unsigned seq[N];
    bit          rnd_valid = 1'b0;
    logic [N-1:0] hs = '0;

    // Behavioural model of the controller.
    bit          m_busy = 1'b0, m_done = 1'b0, m_stall = 1'b0;
    int unsigned m_len = 0, m_cnt = 0, m_ptr = 0;
    logic [N-1:0] m_mask = '1;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_exp = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] src_word(input int i);
        return src_data[i*DW +: DW];
    endfunction

    always @(negedge clock) begin
        logic [N-1:0] elig;
        logic [N-1:0] e_rdy;
        logic [31:0]  e_data;
        logic [31:0]  wd;
        int           g;
        bit           e_wr, ctrl, start, abort, stall_set, fin;
        cyc++;
        elig = src_valid & m_mask;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && elig[(int'(m_ptr) + k) % N]) g = (int'(m_ptr) + k) % N;
        end
        e_wr   = m_busy && !fifo_full && (g >= 0);
        e_rdy  = '0;
        e_data = '0;
        if (e_wr) begin
            e_rdy[g] = 1'b1;
            e_data   = src_word(g);
        end
        check("wrreq", 32'(fifo_wrreq), 32'(e_wr));
        check("src_ready", 32'(src_ready), 32'(e_rdy));
        check("fifo_data", fifo_data, e_data);
        check("capture_done", 32'(capture_done), 32'(m_done));
        if (rd_pend) check("csr_readdata", csr_readdata, rd_exp);

        if (fifo_full && fifo_wrreq) full_wr++;
        hs = src_valid & src_ready;
        if (fifo_wrreq) begin
            int s;
            s = -1;
            for (int i = 0; i < N; i++) if (hs[i]) s = i;
            wlog.push_back('{src: s, data: fifo_data, cyc: cyc});
        end

        rd_pend = csr_read;
        if (csr_read) begin
            case (csr_address)
                2'd0:    rd_exp = 32'(m_mask) << 8;
                2'd1:    rd_exp = m_len;
                2'd2:    rd_exp = {29'd0, m_stall, m_done, m_busy};
                default: rd_exp = m_cnt;
            endcase
        end

        if (reset) begin
            m_busy = 0; m_done = 0; m_stall = 0;
            m_len = 0; m_cnt = 0; m_ptr = 0; m_mask = '1;
            rd_pend = 1; rd_exp = '0;
        end else begin
            wd        = csr_writedata;
            ctrl      = csr_write && csr_address == 2'd0;
            start     = ctrl && wd[0];
            abort     = ctrl && wd[1];
            stall_set = m_busy && fifo_full && (|elig);
            fin       = 0;
            if (csr_write && csr_address == 2'd2) begin
                if (wd[1]) m_done = 0;
                if (wd[2]) m_stall = 0;
            end
            if (e_wr) begin
                m_ptr = (g + 1) % N;
                m_cnt = (m_cnt + 1 < m_len) ? m_cnt + 1 : m_len;
                fin   = (m_cnt == m_len);
            end
            if (m_busy) begin
                if (abort) m_busy = 0;
                else if (fin) begin m_busy = 0; m_done = 1; end
            end else if (start && !abort) begin
                m_cnt = 0; m_stall = 0;
                m_done = (m_len == 0);
                m_busy = (m_len != 0);
            end
            if (stall_set) m_stall = 1;
            if (csr_write && csr_address == 2'd1) m_len = wd[15:0];
            if (ctrl) m_mask = wd[11:8];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            bit keep;
            if (hs[i]) begin
                seq[i]++;
                if (budget[i] > 0) budget[i]--;
            end
            keep = src_valid[i] && !hs[i];
            src_valid[i] = (budget[i] > 0) && (keep || !rnd_valid || ($urandom_range(1, 0) == 1));
            src_data[i*DW +: DW] = {8'(i), 8'h00, 16'(seq[i])};
        end
        hs = '0;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        tick();
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic set_sources(input int unsigned b0, input int unsigned b1, input int unsigned b2,
                               input int unsigned b3, input int unsigned base);
        budget[0] = b0; budget[1] = b1; budget[2] = b2; budget[3] = b3;
        for (int i = 0; i < N; i++) seq[i] = base;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int t = 0; t < limit && capture_done !== 1'b1; t++) tick();
        check(name, 32'(capture_done), 32'd1);
    endtask

    task automatic wait_log(input string name, input int n, input int limit);
        for (int t = 0; t < limit && wlog.size() < n; t++) tick();
        check(name, wlog.size(), n);
    endtask

    initial begin
        logic [31:0] rd;
        set_sources(0, 0, 0, 0, 0);

        // Reset state.
        do_reset();
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_fifo_data", fifo_data, 32'd0);
        check("rst_capture_done", 32'(capture_done), 32'd0);
        csr_rd(2'd0, rd); check("rst_control", rd, 32'h0000_0F00);
        csr_rd(2'd1, rd); check("rst_length", rd, 32'd0);
        csr_rd(2'd2, rd); check("rst_status", rd, 32'd0);
        csr_rd(2'd3, rd); check("rst_count", rd, 32'd0);

        // Single source stream of five words.
        set_sources(100, 0, 0, 0, 32'h10);
        csr_wr(2'd1, 32'd5);
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        wait_done("t1_done_timeout", 100);
        check("t1_nwords", wlog.size(), 5);
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            check("t1_data", wlog[k].data, 32'h10 + k);
            check("t1_src", wlog[k].src, 0);
        end
        csr_rd(2'd3, rd); check("t1_count", rd, 32'd5);
        csr_rd(2'd2, rd); check("t1_status", rd, 32'h2);

        // Four sources, strict rotation from pointer 0.
        do_reset();
        set_sources(100, 100, 100, 100, 0);
        csr_wr(2'd1, 32'd8);
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        wait_done("t2_done_timeout", 100);
        check("t2_nwords", wlog.size(), 8);
        for (int k = 0; k < 8 && k < wlog.size(); k++) check("t2_order", wlog[k].src, k % 4);
        if (wlog.size() == 8) check("t2_back_to_back", wlog[7].cyc - wlog[0].cyc, 7);
        check("t2_ptr", m_ptr, 0);

        // Mask 1010: only sources 1 and 3.
        csr_wr(2'd1, 32'd4);
        wlog.delete();
        csr_wr(2'd0, 32'h0A01);
        wait_done("t3_done_timeout", 100);
        check("t3_nwords", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) check("t3_order", wlog[k].src, (k % 2) ? 3 : 1);

        // Backpressure for three cycles mid-capture.
        do_reset();
        set_sources(100, 0, 0, 0, 32'h100);
        csr_wr(2'd1, 32'd6);
        wlog.delete();
        full_wr = 0;
        csr_wr(2'd0, 32'h0F01);
        tick(); tick();
        fifo_full = 1'b1;
        tick(); tick(); tick();
        fifo_full = 1'b0;
        wait_done("t4_done_timeout", 100);
        check("t4_nwords", wlog.size(), 6);
        for (int k = 0; k < 6 && k < wlog.size(); k++) check("t4_data", wlog[k].data, 32'h100 + k);
        check("t4_write_while_full", full_wr, 0);
        csr_rd(2'd2, rd); check("t4_status", rd, 32'h6);
        csr_wr(2'd2, 32'h4);
        csr_rd(2'd2, rd); check("t4_status_clr", rd, 32'h2);

        // Zero length completes immediately.
        csr_wr(2'd1, 32'd0);
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        check("t5_done", 32'(capture_done), 32'd1);
        tick(); tick(); tick();
        check("t5_nwords", wlog.size(), 0);
        csr_rd(2'd3, rd); check("t5_count", rd, 32'd0);
        csr_rd(2'd2, rd); check("t5_status", rd, 32'h2);

        // Abort after three of ten words, then a full restart.
        set_sources(3, 0, 0, 0, 32'h200);
        csr_wr(2'd1, 32'd10);
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        wait_log("t6_three_words", 3, 50);
        tick(); tick();
        csr_wr(2'd0, 32'h0F02);
        check("t6_ready_after_abort", 32'(src_ready), 32'd0);
        csr_rd(2'd3, rd); check("t6_count", rd, 32'd3);
        csr_rd(2'd2, rd); check("t6_status", rd, 32'd0);
        budget[0] = 100;
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        wait_done("t6_restart_timeout", 100);
        check("t6_nwords", wlog.size(), 10);
        csr_rd(2'd3, rd); check("t6_count_full", rd, 32'd10);

        // Reset in the middle of a capture.
        wlog.delete();
        csr_wr(2'd0, 32'h0F01);
        wait_log("t7_two_words", 2, 50);
        reset = 1'b1;
        tick();
        check("t7_src_ready", 32'(src_ready), 32'd0);
        check("t7_wrreq", 32'(fifo_wrreq), 32'd0);
        check("t7_fifo_data", fifo_data, 32'd0);
        check("t7_capture_done", 32'(capture_done), 32'd0);
        reset = 1'b0;
        csr_rd(2'd1, rd); check("t7_length", rd, 32'd0);
        csr_rd(2'd3, rd); check("t7_count", rd, 32'd0);
        csr_rd(2'd0, rd); check("t7_control", rd, 32'h0F00);

        // Randomized traffic against the model.
        do_reset();
        rnd_valid = 1'b1;
        set_sources(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 0);
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [3:0] msk;
            fifo_full = ($urandom_range(3, 0) == 0);
            msk = ($urandom_range(4, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'hF;
            r = $urandom_range(999, 0);
            if (r < 2) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end else if (r < 40) csr_wr(2'd1, 32'($urandom_range(12, 0)));
            else if (r < 90)     csr_wr(2'd0, {20'd0, msk, 7'd0, 1'b1});
            else if (r < 105)    csr_wr(2'd0, {20'd0, msk, 6'd0, 1'b1, 1'($urandom_range(1, 0))});
            else if (r < 135)    csr_wr(2'd2, 32'($urandom_range(7, 0)));
            else if (r < 250)    csr_rd(2'($urandom_range(3, 0)), rd);
            else                 tick();
        end
        fifo_full = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
